// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencer for the 5-stage pipeline: load-use stalls, MEM-stage branch flushes,
// data-memory freezes with timeout fault, and a saturating count of non-advancing cycles.
module pipeline_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic [4:0]       i_id_rn,
  input  logic [4:0]       i_id_rm,
  input  logic             i_id_uses_rm,
  input  logic             i_ex_memread,
  input  logic [4:0]       i_ex_rd,
  input  logic             i_mem_branch,
  input  logic             i_dmem_req,
  input  logic             i_dmem_ready,
  output logic             o_pc_write,
  output logic             o_ifid_write,
  output logic             o_pipe_hold,
  output logic             o_idex_bubble,
  output logic             o_flush,
  output logic             o_pc_sel_branch,
  output logic             o_fault,
  output logic [CNT_W-1:0] o_stall_count
);

  localparam int unsigned WaitW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

  typedef enum logic [1:0] {StRun, StMemWait, StFault} state_e;

  state_e             r_state, w_state_next;
  logic [WaitW-1:0]   r_wait_cnt, w_wait_cnt_next;
  logic [CNT_W-1:0]   r_stall_cnt;
  logic               w_memw, w_lu;

  assign w_memw = i_dmem_req & ~i_dmem_ready;
  // X31 reads as XZR, so a load targeting it can never feed a consumer.
  assign w_lu   = i_ex_memread & (i_ex_rd != 5'd31) &
                  ((i_ex_rd == i_id_rn) | (i_id_uses_rm & (i_ex_rd == i_id_rm)));

  always_comb begin
    w_state_next    = r_state;
    w_wait_cnt_next = r_wait_cnt;
    o_pc_write      = 1'b1;
    o_ifid_write    = 1'b1;
    o_pipe_hold     = 1'b0;
    o_idex_bubble   = 1'b0;
    o_flush         = 1'b0;
    o_pc_sel_branch = 1'b0;
    o_fault         = 1'b0;
    if (!i_reset_n) begin
      o_pc_write   = 1'b0;
      o_ifid_write = 1'b0;
      o_pipe_hold  = 1'b1;
    end else begin
      unique case (r_state)
        StRun, StMemWait: begin
          if (w_memw) begin
            o_pc_write   = 1'b0;
            o_ifid_write = 1'b0;
            o_pipe_hold  = 1'b1;
            if (r_state == StRun) begin
              w_state_next    = StMemWait;
              w_wait_cnt_next = WaitW'(1);
            end else if (r_wait_cnt == WaitW'(MEM_TIMEOUT - 1)) begin
              w_state_next = StFault;
            end else begin
              w_wait_cnt_next = r_wait_cnt + WaitW'(1);
            end
          end else begin
            w_state_next    = StRun;
            w_wait_cnt_next = '0;
            if (i_mem_branch) begin
              o_flush         = 1'b1;
              o_pc_sel_branch = 1'b1;
            end else if (w_lu) begin
              o_pc_write    = 1'b0;
              o_ifid_write  = 1'b0;
              o_idex_bubble = 1'b1;
            end
          end
        end
        StFault: begin
          o_pc_write   = 1'b0;
          o_ifid_write = 1'b0;
          o_pipe_hold  = 1'b1;
          o_fault      = 1'b1;
        end
        default: w_state_next = StRun;
      endcase
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= StRun;
      r_wait_cnt  <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_cnt_next;
      if (!o_pc_write && !(&r_stall_cnt)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  assign o_stall_count = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: each step applies inputs, checks the Mealy
// outputs mid-cycle, then checks the stall counter after the clock edge.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned CntW = 16;

  logic            clock = 1'b0;
  logic            reset_n;
  logic [4:0]      id_rn, id_rm, ex_rd;
  logic            id_uses_rm, ex_memread, mem_branch, dmem_req, dmem_ready;
  logic            pc_write, ifid_write, pipe_hold, idex_bubble, flush, pc_sel_branch, fault;
  logic [CntW-1:0] stall_count;

  int n_cmp  = 0;
  int n_fail = 0;
  int exp_cnt = 0;

  pipeline_hazard_ctrl #(
    .MEM_TIMEOUT (8),
    .CNT_W       (CntW)
  ) u_dut (
    .i_clock         (clock),
    .i_reset_n       (reset_n),
    .i_id_rn         (id_rn),
    .i_id_rm         (id_rm),
    .i_id_uses_rm    (id_uses_rm),
    .i_ex_memread    (ex_memread),
    .i_ex_rd         (ex_rd),
    .i_mem_branch    (mem_branch),
    .i_dmem_req      (dmem_req),
    .i_dmem_ready    (dmem_ready),
    .o_pc_write      (pc_write),
    .o_ifid_write    (ifid_write),
    .o_pipe_hold     (pipe_hold),
    .o_idex_bubble   (idex_bubble),
    .o_flush         (flush),
    .o_pc_sel_branch (pc_sel_branch),
    .o_fault         (fault),
    .o_stall_count   (stall_count)
  );

  always #5 clock = ~clock;

  // Output vector order: pc_write, ifid_write, pipe_hold, idex_bubble, flush, pc_sel, fault
  localparam logic [6:0] Normal = 7'b1100000;
  localparam logic [6:0] Hold   = 7'b0010000;
  localparam logic [6:0] Bubble = 7'b0001000;
  localparam logic [6:0] Branch = 7'b1100110;
  localparam logic [6:0] Fault  = 7'b0010001;

  function automatic logic [6:0] outs();
    return {pc_write, ifid_write, pipe_hold, idex_bubble, flush, pc_sel_branch, fault};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic [4:0] rn, input logic [4:0] rm, input logic uses_rm,
                        input logic memread, input logic [4:0] rd, input logic br,
                        input logic req, input logic rdy);
    id_rn = rn; id_rm = rm; id_uses_rm = uses_rm; ex_memread = memread; ex_rd = rd;
    mem_branch = br; dmem_req = req; dmem_ready = rdy;
  endtask

  task automatic idle();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Inputs are applied at a negedge; outputs sampled 2 ns later, count after the posedge.
  task automatic step(input string tag, input logic [6:0] exp_outs);
    #2;
    check_eq({tag, ".outs"}, 32'(outs()), 32'(exp_outs));
    @(posedge clock);
    if (!exp_outs[6]) exp_cnt++;
    @(negedge clock);
    check_eq({tag, ".cnt"}, 32'(stall_count), 32'(exp_cnt));
  endtask

  initial begin
    idle();
    reset_n = 1'b0;
    #3;
    check_eq("rst.outs", 32'(outs()), 32'(Hold));
    check_eq("rst.cnt", 32'(stall_count), 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    idle();                                               step("idle", Normal);
    set_in(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0); step("lu_rn", Bubble);
    set_in(5'd5, 5'd0, 1'b0, 1'b1, 5'd31, 1'b0, 1'b0, 1'b0); step("lu_rd31", Normal);
    set_in(5'd31, 5'd0, 1'b0, 1'b1, 5'd31, 1'b0, 1'b0, 1'b0); step("lu_xzr", Normal);
    set_in(5'd0, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0); step("rm_unused", Normal);
    set_in(5'd0, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0); step("rm_used", Bubble);
    set_in(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0); step("br_over_lu", Branch);
    set_in(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0); step("memw_over_br", Hold);

    // Memory wait: the cycle above was the first held cycle, two more then release.
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0); step("wait2_br_ign", Hold);
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0); step("wait3", Hold);
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1); step("release", Normal);
    idle();                                               step("back_run", Normal);
    // A fresh wait after release must restart from RUN semantics with lu honoured on exit.
    set_in(5'd3, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0); step("wait_lu", Hold);
    set_in(5'd3, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b1, 1'b1); step("rel_lu", Bubble);
    idle();                                               step("run2", Normal);

    // Timeout: 8 held cycles, then FAULT.
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step($sformatf("to_hold%0d", i), Hold);
    step("to_fault", Fault);
    idle();                                               step("fault_sticky", Fault);
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1); step("fault_ready", Fault);

    // Async reset out of FAULT.
    #2;
    reset_n = 1'b0;
    exp_cnt = 0;
    #1;
    check_eq("rst_fault.outs", 32'(outs()), 32'(Hold));
    check_eq("rst_fault.cnt", 32'(stall_count), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    idle();                                               step("after_rst", Normal);

    // Async reset mid-wait: no pending MEM_WAIT state survives.
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0); step("mw1", Hold);
    step("mw2", Hold);
    #1;
    reset_n = 1'b0;
    exp_cnt = 0;
    #1;
    check_eq("rst_wait.cnt", 32'(stall_count), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1); step("rst_wait_run", Normal);
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0); step("br_plain", Branch);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
